// File: rtl/ppu_line_buffer.sv
// Ping-pong scanline buffer between a PPU pixel stream and a VGA raster.
// Each 256-pixel PPU line is shown 2x horizontally and 2x vertically, with borders on both sides.
module ppu_line_buffer #(
  parameter int          H_OFFSET     = 64,
  parameter logic [14:0] BORDER_COLOR = 15'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ppu_frame_start,
  input  logic        ppu_line_start,
  input  logic        ppu_pixel_valid,
  input  logic [14:0] ppu_pixel,
  input  logic [9:0]  vga_hcounter,
  input  logic [9:0]  vga_vcounter,
  input  logic [9:0]  next_pixel_x,
  output logic [14:0] pixel,
  output logic        sync,
  output logic        border,
  output logic        underrun
);

  localparam logic [10:0] WIN_LO = 11'(H_OFFSET);
  localparam logic [10:0] WIN_HI = 11'(H_OFFSET + 512);

  // Two 256-entry banks side by side; the top address bit selects the bank.
  logic [14:0] mem [0:511];

  logic [8:0] wr_x;
  logic       wr_bank;
  logic       rd_bank;
  logic       line_ready;
  logic       armed;

  logic [8:0] eff_x;
  logic       do_write;
  logic       complete;
  logic [9:0] row_next;
  logic       boundary;
  logic       swap;
  logic       in_win;
  logic [7:0] rd_addr;

  // PPU side is valid-only: a pixel is taken on every cycle ppu_pixel_valid is high
  // (no backpressure). A start pulse clears the column before that cycle's write.
  always_comb begin
    eff_x    = (ppu_line_start || ppu_frame_start) ? 9'd0 : wr_x;
    do_write = ppu_pixel_valid && (armed || ppu_line_start) && !eff_x[8];
    complete = do_write && (eff_x[7:0] == 8'hFF);
  end

  always_ff @(posedge clk) begin
    if (do_write) mem[{wr_bank, eff_x[7:0]}] <= ppu_pixel;
  end

  // armed stays low after reset so a line interrupted by reset is never resumed mid-way.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_x    <= 9'd0;
      wr_bank <= 1'b0;
      armed   <= 1'b0;
    end else begin
      if (ppu_line_start) armed <= 1'b1;
      wr_x <= do_write ? eff_x + 9'd1 : eff_x;
      if (complete) wr_bank <= ~wr_bank;
    end
  end

  // Swaps only happen entering an even visible row, so each line covers two rows.
  always_comb begin
    row_next = (vga_vcounter == 10'd524) ? 10'd0 : vga_vcounter + 10'd1;
    boundary = (vga_hcounter == 10'd799) && !row_next[0] && (row_next < 10'd480);
    swap     = boundary && line_ready;
    in_win   = ({1'b0, next_pixel_x} >= WIN_LO) && ({1'b0, next_pixel_x} < WIN_HI) &&
               (vga_vcounter < 10'd480);
    rd_addr  = 8'((next_pixel_x - 10'(H_OFFSET)) >> 1);
  end

  // The most recently completed line always sits in ~wr_bank, so a second
  // completion before the swap simply makes the newer line the one shown.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_bank    <= 1'b1;
      line_ready <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      if (swap) rd_bank <= ~wr_bank;
      if (boundary && !line_ready) underrun <= 1'b1;
      if (ppu_frame_start) line_ready <= 1'b0;
      else if (complete)   line_ready <= 1'b1;
      else if (swap)       line_ready <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pixel  <= BORDER_COLOR;
      border <= 1'b1;
      sync   <= 1'b0;
    end else begin
      pixel  <= in_win ? mem[{rd_bank, rd_addr}] : BORDER_COLOR;
      border <= !in_win;
      sync   <= (next_pixel_x == 10'd0) && (vga_vcounter == 10'd0);
    end
  end

endmodule

// File: tb/tb_ppu_line_buffer.sv
// Directed bench for ppu_line_buffer: line fill, 2x scaling, borders, underrun,
// overlong lines, newest-line-wins, reset recovery and swap/complete coincidence.
module tb_ppu_line_buffer;

  localparam logic [14:0] BC = 15'h1234;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        ppu_frame_start = 1'b0;
  logic        ppu_line_start = 1'b0;
  logic        ppu_pixel_valid = 1'b0;
  logic [14:0] ppu_pixel = 15'd0;
  logic [9:0]  vga_hcounter = 10'd0;
  logic [9:0]  vga_vcounter = 10'd0;
  logic [9:0]  next_pixel_x = 10'd700;
  logic [14:0] pixel;
  logic        sync;
  logic        border;
  logic        underrun;

  int vectors = 0;
  int miscompares = 0;
  logic [14:0] wr_model [256];
  logic [14:0] shown [256];
  logic [15:0] exp_q [$];

  ppu_line_buffer #(.H_OFFSET(64), .BORDER_COLOR(BC)) dut (
    .clk(clk), .reset(reset), .ppu_frame_start(ppu_frame_start),
    .ppu_line_start(ppu_line_start), .ppu_pixel_valid(ppu_pixel_valid),
    .ppu_pixel(ppu_pixel), .vga_hcounter(vga_hcounter), .vga_vcounter(vga_vcounter),
    .next_pixel_x(next_pixel_x), .pixel(pixel), .sync(sync), .border(border),
    .underrun(underrun)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  function automatic logic [14:0] pat(input logic [14:0] base, input bit rev, input int i);
    return rev ? base + 15'(255 - i) : base + 15'(i);
  endfunction

  task automatic write_line(input logic [14:0] base, input bit rev, input int count, input bit merge);
    if (!merge) begin
      ppu_line_start = 1'b1;
      tick();
      ppu_line_start = 1'b0;
    end
    for (int i = 0; i < count; i++) begin
      if (merge && i == 0) ppu_line_start = 1'b1;
      ppu_pixel_valid = 1'b1;
      ppu_pixel = pat(base, rev, i);
      if (i < 256) wr_model[i] = pat(base, rev, i);
      tick();
      ppu_line_start = 1'b0;
    end
    ppu_pixel_valid = 1'b0;
  endtask

  task automatic junk_writes(input int count);
    for (int i = 0; i < count; i++) begin
      ppu_pixel_valid = 1'b1;
      ppu_pixel = 15'h5555;
      tick();
    end
    ppu_pixel_valid = 1'b0;
  endtask

  task automatic line_boundary(input logic [9:0] vc);
    vga_hcounter = 10'd799;
    vga_vcounter = vc;
    tick();
    vga_hcounter = 10'd0;
  endtask

  task automatic pixel_at(input string tag, input logic [9:0] row, input logic [9:0] x,
                          input logic [14:0] exp_px, input logic exp_border);
    vga_vcounter = row;
    next_pixel_x = x;
    tick();
    check({tag, "_px"}, {1'b0, pixel}, {1'b0, exp_px});
    check({tag, "_border"}, {15'd0, border}, {15'd0, exp_border});
    next_pixel_x = 10'd700;
  endtask

  // Full row sweep against the shown-line model; sync is checked on every cycle.
  task automatic sweep_row(input string tag, input logic [9:0] row, input int exp_syncs);
    int syncs;
    logic [15:0] e;
    logic in_win;
    syncs = 0;
    vga_vcounter = row;
    for (int x = 0; x < 800; x++) begin
      next_pixel_x = 10'(x);
      in_win = (x >= 64) && (x < 576);
      exp_q.push_back(in_win ? {1'b0, shown[(x - 64) / 2]} : {1'b1, BC});
      tick();
      e = exp_q.pop_front();
      check({tag, "_px"}, {1'b0, pixel}, {1'b0, e[14:0]});
      check({tag, "_border"}, {15'd0, border}, {15'd0, e[15]});
      check({tag, "_sync"}, {15'd0, sync}, {15'd0, (x == 0 && row == 10'd0)});
      if (sync) syncs++;
    end
    next_pixel_x = 10'd700;
    check({tag, "_sync_count"}, 16'(syncs), 16'(exp_syncs));
  endtask

  initial begin
    // Reset state
    reset = 1'b1;
    #1;
    check("rst_pixel", {1'b0, pixel}, {1'b0, BC});
    check("rst_border", {15'd0, border}, 16'd1);
    check("rst_sync", {15'd0, sync}, 16'd0);
    check("rst_underrun", {15'd0, underrun}, 16'd0);
    tick();
    reset = 1'b0;
    tick();

    // No line written when row 0 begins
    line_boundary(10'd524);
    check("underrun_set", {15'd0, underrun}, 16'd1);
    for (int i = 0; i < 5; i++) tick();
    write_line(15'h0000, 1'b0, 256, 1'b0);
    line_boundary(10'd1);
    check("underrun_sticky", {15'd0, underrun}, 16'd1);

    // Line of pixel[i] = i shown on row 0
    do_reset();
    check("after_reset_underrun", {15'd0, underrun}, 16'd0);
    write_line(15'h0000, 1'b0, 256, 1'b0);
    line_boundary(10'd524);
    check("fill_underrun", {15'd0, underrun}, 16'd0);
    pixel_at("x64", 10'd0, 10'd64, 15'd0, 1'b0);
    pixel_at("x65", 10'd0, 10'd65, 15'd0, 1'b0);
    pixel_at("x66", 10'd0, 10'd66, 15'd1, 1'b0);
    pixel_at("x575", 10'd0, 10'd575, 15'd255, 1'b0);
    pixel_at("x10", 10'd0, 10'd10, BC, 1'b1);
    pixel_at("x600", 10'd0, 10'd600, BC, 1'b1);
    pixel_at("x576", 10'd0, 10'd576, BC, 1'b1);
    pixel_at("x63", 10'd0, 10'd63, BC, 1'b1);
    pixel_at("row480", 10'd480, 10'd100, BC, 1'b1);
    shown = wr_model;
    sweep_row("ramp_row0", 10'd0, 1);

    // 300 pixels after one line start: only the first 256 count, once
    do_reset();
    write_line(15'h2000, 1'b0, 300, 1'b0);
    line_boundary(10'd524);
    check("long_underrun", {15'd0, underrun}, 16'd0);
    shown = wr_model;
    sweep_row("long_row0", 10'd0, 1);
    line_boundary(10'd1);
    check("long_ready_once", {15'd0, underrun}, 16'd1);

    // Lines A then B before the boundary; B has its start merged with pixel 0
    do_reset();
    write_line(15'h4000, 1'b0, 256, 1'b0);
    write_line(15'h6000, 1'b1, 256, 1'b1);
    line_boundary(10'd524);
    shown = wr_model;
    sweep_row("newest_row0", 10'd0, 1);
    line_boundary(10'd0);
    check("odd_row_no_swap", {15'd0, underrun}, 16'd0);
    pixel_at("odd_row_keep", 10'd1, 10'd64, 15'h6000 + 15'd255, 1'b0);
    line_boundary(10'd1);
    check("ready_cleared", {15'd0, underrun}, 16'd1);

    // Reset in the middle of a line, stray writes, then a full line
    do_reset();
    write_line(15'h7000, 1'b0, 100, 1'b0);
    do_reset();
    junk_writes(10);
    write_line(15'h0300, 1'b0, 256, 1'b0);
    line_boundary(10'd524);
    check("recover_underrun", {15'd0, underrun}, 16'd0);
    shown = wr_model;
    sweep_row("recover_row0", 10'd0, 1);

    // Without a line start after reset no writes are accepted
    do_reset();
    junk_writes(256);
    line_boundary(10'd524);
    check("unarmed_underrun", {15'd0, underrun}, 16'd1);

    // Line completes on the same cycle as a row-0 boundary
    do_reset();
    write_line(15'h0A00, 1'b0, 255, 1'b0);
    ppu_pixel_valid = 1'b1;
    ppu_pixel = 15'h0A00 + 15'd255;
    wr_model[255] = 15'h0A00 + 15'd255;
    vga_hcounter = 10'd799;
    vga_vcounter = 10'd524;
    tick();
    ppu_pixel_valid = 1'b0;
    vga_hcounter = 10'd0;
    check("coincide_underrun", {15'd0, underrun}, 16'd1);
    line_boundary(10'd1);
    shown = wr_model;
    sweep_row("coincide_row2", 10'd2, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
